// File: rtl/stream_sram_loader.sv
// Byte-stream to SRAM loader: skips a PPM-style text header, packs payload bytes
// MSB-first into DATA_WIDTH words and writes them to consecutive addresses.
module stream_sram_loader #(
   parameter int unsigned           DATA_WIDTH     = 16,
   parameter int unsigned           ADDR_WIDTH     = 18,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
   parameter int unsigned           MAX_WORDS      = 262144,
   parameter int unsigned           HEADER_LINES   = 3,
   parameter int unsigned           TIMEOUT_CYCLES = 50000000,
   parameter logic [7:0]            PAD_BYTE       = 8'h00
) (
   input  logic                  Clock_50,
   input  logic                  Resetn,
   input  logic                  Start_i,
   input  logic [7:0]            Rx_data_i,
   input  logic                  Rx_valid_i,
   output logic [ADDR_WIDTH-1:0] SRAM_address_o,
   output logic [DATA_WIDTH-1:0] SRAM_write_data_o,
   output logic                  SRAM_we_n_o,
   output logic                  Busy_o,
   output logic                  Done_o,
   output logic                  Overflow_o,
   output logic [ADDR_WIDTH:0]   Word_count_o
);

   localparam int BYTES      = DATA_WIDTH / 8;
   localparam int BCNT_W     = $clog2(BYTES + 1);
   localparam int LINE_W     = (HEADER_LINES > 0) ? $clog2(HEADER_LINES + 1) : 1;
   localparam int IDLE_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CNT_W      = ADDR_WIDTH + 1;
   // The final idle cycle is the one in which the timeout decision is taken.
   localparam int IDLE_LIMIT = (TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 2 : 0;

   localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES - 1);
   localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'((HEADER_LINES > 0) ? HEADER_LINES - 1 : 0);
   localparam logic [IDLE_W-1:0] IDLE_END  = IDLE_W'(IDLE_LIMIT);
   localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_WORDS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEADER,
      S_DATA,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] pack_buf;
   logic [DATA_WIDTH-1:0] pad_word;
   logic [DATA_WIDTH-1:0] wdata;
   logic [BCNT_W-1:0]     byte_cnt;
   logic [LINE_W-1:0]     line_cnt;
   logic [IDLE_W-1:0]     idle_cnt;
   logic                  seen_byte;
   logic                  we_n;
   logic                  busy;
   logic                  done;
   logic                  overflow;
   logic [ADDR_WIDTH-1:0] addr;
   logic [CNT_W-1:0]      word_count;
   logic [CNT_W-1:0]      words_issued;
   logic                  loading;
   logic                  timeout;
   logic                  full;

   function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w,
                                                      input logic [7:0]            b);
      logic [DATA_WIDTH+7:0] t;
      t = {w, b};
      return t[DATA_WIDTH-1:0];
   endfunction

   // Partial word completed with PAD_BYTE so its first byte still lands in the MSBs.
   always_comb begin
      // NOTE: default assignment first so every path drives pad_word and no latch is inferred.
      pad_word = pack_buf;
      for (int i = 0; i < BYTES; i++) begin
         if (i + int'(byte_cnt) < BYTES) pad_word = shift_in(pad_word, PAD_BYTE);
      end
   end

   assign loading = (state == S_HEADER) || (state == S_DATA);
   assign timeout = loading && seen_byte && !Rx_valid_i && (idle_cnt == IDLE_END);
   // words_issued counts words already handed to the write register, so a byte
   // arriving during the last permitted write cycle is correctly seen as overflow.
   assign full    = (words_issued == MAX_CNT);

   always_ff @(posedge Clock_50 or negedge Resetn) begin
      if (!Resetn) begin
         state        <= S_IDLE;
         pack_buf     <= '0;
         wdata        <= '0;
         byte_cnt     <= '0;
         line_cnt     <= '0;
         idle_cnt     <= '0;
         seen_byte    <= 1'b0;
         we_n         <= 1'b1;
         busy         <= 1'b0;
         done         <= 1'b0;
         overflow     <= 1'b0;
         addr         <= BASE_ADDR;
         word_count   <= '0;
         words_issued <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every read sees the pre-edge value
         // and later assignments in this block override earlier ones without ordering races.
         if (!we_n) begin
            we_n       <= 1'b1;
            word_count <= word_count + CNT_W'(1);
            addr       <= addr + ADDR_WIDTH'(1);
         end

         if (loading) begin
            if (Rx_valid_i) begin
               idle_cnt  <= '0;
               seen_byte <= 1'b1;
            end else if (seen_byte && idle_cnt != IDLE_END) begin
               idle_cnt <= idle_cnt + IDLE_W'(1);
            end
         end

         case (state)
            S_IDLE, S_DONE: begin
               if (Start_i) begin
                  state        <= (HEADER_LINES == 0) ? S_DATA : S_HEADER;
                  busy         <= 1'b1;
                  done         <= 1'b0;
                  pack_buf     <= '0;
                  byte_cnt     <= '0;
                  line_cnt     <= '0;
                  idle_cnt     <= '0;
                  seen_byte    <= 1'b0;
                  overflow     <= 1'b0;
                  addr         <= BASE_ADDR;
                  word_count   <= '0;
                  words_issued <= '0;
               end
            end

            S_HEADER: begin
               if (Rx_valid_i) begin
                  if (Rx_data_i == 8'h0A) begin
                     line_cnt <= line_cnt + LINE_W'(1);
                     if (line_cnt == LAST_LINE) state <= S_DATA;
                  end
               end else if (timeout) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end

            S_DATA: begin
               if (Rx_valid_i) begin
                  if (full) begin
                     overflow <= 1'b1;
                  end else if (byte_cnt == LAST_BYTE) begin
                     wdata        <= shift_in(pack_buf, Rx_data_i);
                     we_n         <= 1'b0;
                     pack_buf     <= '0;
                     byte_cnt     <= '0;
                     words_issued <= words_issued + CNT_W'(1);
                  end else begin
                     pack_buf <= shift_in(pack_buf, Rx_data_i);
                     byte_cnt <= byte_cnt + BCNT_W'(1);
                  end
               end else if (timeout) begin
                  if (byte_cnt != '0) begin
                     state <= S_FLUSH;
                  end else begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end

            S_FLUSH: begin
               if (Rx_valid_i) overflow <= 1'b1;
               if (byte_cnt != '0) begin
                  wdata        <= pad_word;
                  we_n         <= 1'b0;
                  pack_buf     <= '0;
                  byte_cnt     <= '0;
                  words_issued <= words_issued + CNT_W'(1);
               end else if (!we_n) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end

            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   assign SRAM_address_o    = addr;
   assign SRAM_write_data_o = wdata;
   assign SRAM_we_n_o       = we_n;
   assign Busy_o            = busy;
   assign Done_o            = done;
   assign Overflow_o        = overflow;
   assign Word_count_o      = word_count;

endmodule

// File: doc/stream_sram_loader.md
Name: stream_sram_loader

Overview:
- Synthesizable loader that takes a UART-style byte stream, strips a configurable number of text header lines (PPM-style), and packs payload bytes MSB-first into SRAM words.
- Writes each packed word to consecutive SRAM addresses.
- Declares completion after an idle timeout.
- Sits between the UART receiver and the SRAM interface, ahead of the VGA display path. Replaces the fixed 3-line / 16-bit loading scheme.

Parameters:
DATA_WIDTH, 16, SRAM word width; multiple of 8, range 8..64
ADDR_WIDTH, 18, SRAM address width
BASE_ADDR, 0, first write address
MAX_WORDS, 262144, words accepted before overflow
HEADER_LINES, 3, LF (8'h0A) bytes to discard before payload; 0 means no header
TIMEOUT_CYCLES, 50000000, idle cycles after the last byte before finishing
PAD_BYTE, 8'h00, fill value for the unused bytes of a partial final word

Ports:
Clock_50  in  1  clock
Resetn  in  1  asynchronous active-low reset
Start_i  in  1  one-cycle arm pulse
Rx_data_i  in  8  received byte
Rx_valid_i  in  1  one-cycle byte strobe; no backpressure
SRAM_address_o  out  ADDR_WIDTH  write address
SRAM_write_data_o  out  DATA_WIDTH  write data
SRAM_we_n_o  out  1  active-low write enable
Busy_o  out  1  high in S_HEADER, S_DATA, S_FLUSH
Done_o  out  1  high in S_DONE
Overflow_o  out  1  sticky; payload bytes were dropped
Word_count_o  out  ADDR_WIDTH+1  number of words written

Behaviour:
- Reset (asynchronous, active-low):
  - state S_IDLE, SRAM_we_n_o=1, SRAM_address_o=BASE_ADDR, SRAM_write_data_o=0.
  - All counters 0; Busy_o, Done_o, Overflow_o = 0.
  - Reset mid-load aborts immediately; no further writes.
- States:
  - S_IDLE: Start_i -> S_HEADER, or S_DATA if HEADER_LINES=0. Clears counters, Overflow_o and the pack buffer. Rx_valid_i ignored.
  - S_HEADER: each valid byte is discarded. A valid byte equal to 8'h0A increments line_cnt; the byte that makes line_cnt==HEADER_LINES moves to S_DATA. The next byte is payload.
  - S_DATA: each valid byte shifts into the pack buffer, MSB-first (first byte -> [DATA_WIDTH-1:DATA_WIDTH-8]). 8'h0A has no special meaning here.
    - When byte DATA_WIDTH/8 of a word arrives, the word is copied to the write register.
    - SRAM_we_n_o=0 for exactly the following cycle, with SRAM_address_o = BASE_ADDR + Word_count_o.
    - Word_count_o increments in that write cycle; the address advances after it.
    - A byte arriving during the write cycle is accepted into the emptied pack buffer; no stall, no loss.
  - Timeout: the idle counter runs only after the first byte received since Start. It resets on every Rx_valid_i and reaching TIMEOUT_CYCLES-1 idle cycles ends the current state:
    - In S_HEADER: -> S_DONE, 0 words written.
    - In S_DATA with a partial word: -> S_FLUSH.
    - In S_DATA otherwise: -> S_DONE.
  - S_FLUSH: fills the remaining low bytes with PAD_BYTE, does one write cycle, then -> S_DONE. Bytes arriving in S_FLUSH are dropped and set Overflow_o.
  - S_DONE: Done_o=1. Start_i re-arms exactly as from S_IDLE. Rx_valid_i ignored.
- Overflow: once Word_count_o==MAX_WORDS, payload bytes are dropped, Overflow_o=1, and no write occurs. The timeout still ends the load.
- Start_i while Busy_o is ignored.
- Start_i and Rx_valid_i in the same cycle in S_IDLE: the byte is ignored.
- SRAM_write_data_o holds its last written value between writes.
- SRAM_address_o arithmetic wraps modulo 2^ADDR_WIDTH. Behaviour is only required when BASE_ADDR+MAX_WORDS <= 2^ADDR_WIDTH.
- Latency: write strobe 1 cycle after the completing byte; Done_o 1 cycle after the final write or timeout.

Test Plan:
1. DATA_WIDTH=16, HEADER_LINES=3. Send "P6\n2 1\n255\n" then bytes 01..06, one byte every 8 cycles -> three writes: addr 0=16'h0102, 1=16'h0304, 2=16'h0506. Then Done_o=1, Word_count_o=3, Overflow_o=0.
2. Same stream with 7 payload bytes and TIMEOUT_CYCLES=20 -> fourth write, addr 3=16'h0700 (PAD_BYTE=00), 21 cycles after byte 07. Then Done_o.
3. DATA_WIDTH=32, HEADER_LINES=0, BASE_ADDR=100. Bytes AA BB CC DD 11 22 33 44 back-to-back every cycle -> addr 100=32'hAABBCCDD, addr 101=32'h11223344. Payload 0A is stored, not treated as a header line.
4. MAX_WORDS=2, DATA_WIDTH=16. Send 6 payload bytes -> exactly 2 writes and Overflow_o=1. Word_count_o stays 2 and Done_o follows the timeout.
5. Only "P6\n" sent with HEADER_LINES=3, then idle -> S_DONE after timeout, no SRAM_we_n_o low pulse, Word_count_o=0.
6. Resetn low for 1 cycle during S_DATA after 3 words -> all outputs return to reset values, no write afterwards. A new Start_i and stream load from BASE_ADDR again.
